// File: rtl/bram_sweep_pkg.sv
// Shared types and constants for the block-RAM sweep controller.
// Build option: define BRAM_SWEEP_VERIFY_EN to include the read-back verify
// states (RD_B, CHK). Without it, each word takes only read and write cycles.
package bram_sweep_pkg;

    localparam int CYCLES_PER_WORD_VERIFY = 4;
    localparam int CYCLES_PER_WORD_FAST   = 2;

`ifdef BRAM_SWEEP_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_WR_B = 3'd2,
        ST_RD_B = 3'd3,
        ST_CHK  = 3'd4,
        ST_DONE = 3'd5
    } sweep_state_t;

    localparam int CYCLES_PER_WORD = CYCLES_PER_WORD_VERIFY;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_WR_B = 3'd2,
        ST_DONE = 3'd5
    } sweep_state_t;

    localparam int CYCLES_PER_WORD = CYCLES_PER_WORD_FAST;
`endif

endpackage

// File: rtl/bram_sweep_ctrl.sv
// Dual-port block-RAM sweep controller: walks a window of WORD_COUNT words
// starting at START_ADDR (wrapping at the top of memory). Each word is read on
// port A and written back plus INCR on port B.
// Build option: BRAM_SWEEP_VERIFY_EN adds a port-B read-back and compare per
// word; a mismatch stops the sweep with error raised.
// RAM port outputs are decoded from the state because write data depends on
// the same-cycle port-A read data.
module bram_sweep_ctrl
    import bram_sweep_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 10,
    parameter int START_ADDR = 0,
    parameter int WORD_COUNT = 8,
    parameter int INCR       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] q_a,
    input  logic [DATA_W-1:0] q_b,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic              we_b,
    output logic [DATA_W-1:0] d_b,
    output logic [DATA_W-1:0] display_value,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(WORD_COUNT - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
    localparam logic [DATA_W-1:0] INCR_W    = DATA_W'(INCR);

    // The window may not be larger than the address space.
    if ((WORD_COUNT < 1) || (WORD_COUNT > (1 << ADDR_W))) begin : g_bad_word_count
        $error("bram_sweep_ctrl: WORD_COUNT must be in 1..2**ADDR_W");
    end

    sweep_state_t      state_r;
    sweep_state_t      state_s;
    logic [ADDR_W-1:0] idx_r;
    logic [ADDR_W-1:0] cur_addr_s;
    logic              last_word_s;
    logic [DATA_W-1:0] display_value_r;
    logic              busy_r;
    logic              done_r;

    // Address arithmetic is ADDR_W wide so the window wraps naturally.
    assign cur_addr_s  = BASE_ADDR + idx_r;
    assign last_word_s = (idx_r == LAST_IDX);

`ifdef BRAM_SWEEP_VERIFY_EN
    logic [DATA_W-1:0] expected_r;
    logic              error_r;
    logic              mismatch_s;

    assign mismatch_s = (q_b != expected_r);
    assign error      = error_r;
`else
    logic unused_q_b_s;

    assign unused_q_b_s = ^q_b;
    assign error        = 1'b0;
`endif

    assign display_value = display_value_r;
    assign busy          = busy_r;
    assign done          = done_r;

    // Next-state selection and RAM port drive for the current state.
    always_comb begin
        state_s = state_r;
        addr_a  = {ADDR_W{1'b0}};
        addr_b  = {ADDR_W{1'b0}};
        we_b    = 1'b0;
        d_b     = {DATA_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RD_A;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD_A: begin
                addr_a  = cur_addr_s;
                state_s = ST_WR_B;
            end
            ST_WR_B: begin
                addr_b = cur_addr_s;
                we_b   = 1'b1;
                d_b    = q_a + INCR_W;
`ifdef BRAM_SWEEP_VERIFY_EN
                state_s = ST_RD_B;
`else
                if (last_word_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RD_A;
                end
`endif
            end
`ifdef BRAM_SWEEP_VERIFY_EN
            ST_RD_B: begin
                addr_b  = cur_addr_s;
                state_s = ST_CHK;
            end
            ST_CHK: begin
                if (mismatch_s || last_word_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RD_A;
                end
            end
`endif
            ST_DONE: begin
                if (start) begin
                    state_s = ST_RD_A;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Word index, result/status registers and the verify reference value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r           <= {ADDR_W{1'b0}};
            display_value_r <= {DATA_W{1'b0}};
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
`ifdef BRAM_SWEEP_VERIFY_EN
            expected_r      <= {DATA_W{1'b0}};
            error_r         <= 1'b0;
`endif
        end else begin
            busy_r <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            done_r <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        idx_r   <= {ADDR_W{1'b0}};
`ifdef BRAM_SWEEP_VERIFY_EN
                        error_r <= 1'b0;
`endif
                    end else begin
                        idx_r <= idx_r;
                    end
                end
                ST_WR_B: begin
                    display_value_r <= d_b;
`ifdef BRAM_SWEEP_VERIFY_EN
                    expected_r      <= d_b;
`else
                    if (!last_word_s) begin
                        idx_r <= idx_r + IDX_ONE;
                    end else begin
                        idx_r <= idx_r;
                    end
`endif
                end
`ifdef BRAM_SWEEP_VERIFY_EN
                ST_CHK: begin
                    if (mismatch_s) begin
                        display_value_r <= q_b;
                        error_r         <= 1'b1;
                    end else if (!last_word_s) begin
                        idx_r <= idx_r + IDX_ONE;
                    end else begin
                        idx_r <= idx_r;
                    end
                end
`endif
                default: begin
                    idx_r <= idx_r;
                end
            endcase
        end
    end

endmodule
